// File: rtl/multdiv_wb.sv
// multdiv_wb: iterative signed 32-bit multiply/divide feeding the register-file write port.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign applied at the end.
// Optional build macro MULTDIV_DIV0_EARLY_EN: a divide by zero skips the iterations and
// completes one cycle after the start.
module multdiv_wb #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_destReg,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [4:0]       data_destReg,
    output logic             ctrl_wbEnable,
    output logic             busy
);

`ifdef MULTDIV_DIV0_EARLY_EN
    localparam bit DIV0_EARLY = 1'b1;
`else
    localparam bit DIV0_EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;       // iterations done; bit 5 set means the finalize cycle
    logic [63:0] acc;       // mul: {partial hi, multiplier lo}; div: {remainder, quotient}
    logic [31:0] opnd;      // |multiplicand| or |divisor|
    logic        neg;       // result sign
    logic [4:0]  dest_q;

    logic        start_ok, take_mul, take_div, iter, finish;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_rem;
    logic        div_ge;
    logic [63:0] mul_signed;
    logic [31:0] div_q;
    logic        mul_exc, div0;

    assign start_ok = (state == IDLE) || (state == DONE);
    assign take_mul = start_ok && ctrl_MULT;
    assign take_div = start_ok && ctrl_DIV && !ctrl_MULT;
    assign iter     = ((state == MUL) || (state == DIV)) && !cnt[5];
    assign finish   = ((state == MUL) || (state == DIV)) && cnt[5];

    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    // one iteration step for each operation
    assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_rem   = div_shift[31:0] - opnd;

    // sign correction and overflow detection at completion
    assign mul_signed = neg ? -acc : acc;
    assign mul_exc    = !((&mul_signed[63:31]) || !(|mul_signed[63:31]));
    assign div_q      = neg ? -acc[31:0] : acc[31:0];
    assign div0       = (opnd == 32'd0);

    // state register
    always_ff @(posedge clock) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    // next-state: starts only from IDLE/DONE, MULT has priority
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (take_mul)      state_nxt = MUL;
                else if (take_div) state_nxt = DIV;
                else               state_nxt = IDLE;
            end
            MUL, DIV: if (cnt[5]) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state: busy during iterations, strobes in DONE
    always_comb begin
        busy           = iter;
        data_resultRDY = (state == DONE);
        ctrl_wbEnable  = (state == DONE) && (data_destReg != 5'd0);
    end

    // operand capture and iteration datapath
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            dest_q <= '0;
        end else if (take_mul) begin
            cnt    <= '0;
            acc    <= {32'd0, abs_b};
            opnd   <= abs_a;
            neg    <= data_operandA[31] ^ data_operandB[31];
            dest_q <= ctrl_destReg;
        end else if (take_div) begin
            // early divide-by-zero jumps straight to the finalize cycle
            cnt    <= (DIV0_EARLY && (data_operandB == 32'd0)) ? 6'd32 : 6'd0;
            acc    <= {32'd0, abs_a};
            opnd   <= abs_b;
            neg    <= data_operandA[31] ^ data_operandB[31];
            dest_q <= ctrl_destReg;
        end else if (iter) begin
            cnt <= cnt + 6'd1;
            if (state == MUL)
                acc <= {mul_sum, acc[31:1]};
            else if (div_ge)
                acc <= {div_rem, acc[30:0], 1'b1};
            else
                acc <= {div_shift[31:0], acc[30:0], 1'b0};
        end
    end

    // result registers, held until the next completion
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_destReg   <= '0;
        end else if (finish) begin
            data_destReg <= dest_q;
            if (state == MUL) begin
                data_result    <= mul_signed[31:0];
                data_exception <= mul_exc;
            end else begin
                // quotient magnitude 2^31 with positive sign is the only divide overflow
                data_result    <= div0 ? 32'd0 : div_q;
                data_exception <= div0 || (!neg && acc[31]);
            end
        end
    end

endmodule

// File: tb/tb_multdiv_wb.sv
// Scoreboard bench for multdiv_wb: stimulus pushes expected results, a negedge monitor checks them.
module tb_multdiv_wb;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [4:0]  ctrl_destReg = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, ctrl_wbEnable, busy;
    logic [4:0]  data_destReg;

    multdiv_wb #(.WIDTH(32)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .ctrl_destReg(ctrl_destReg),
        .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
        .data_destReg(data_destReg), .ctrl_wbEnable(ctrl_wbEnable), .busy(busy)
    );

    always #5 clock = ~clock;

`ifdef MULTDIV_DIV0_EARLY_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  dest;
        logic        wb;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every result strobe must match the oldest expectation
    always @(negedge clock) begin
        if (!ctrl_reset && data_resultRDY) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(data_result), 64'(e.res));
                chk("exception", 64'(data_exception), 64'(e.exc));
                chk("destreg", 64'(data_destReg), 64'(e.dest));
                chk("wbenable", 64'(ctrl_wbEnable), 64'(e.wb));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // called right after a negedge; drives a one-cycle start pulse
    task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input bit expect_it, input logic [31:0] r,
                            input logic e, input int lat, output int c0);
        exp_t x;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        data_operandA = a;
        data_operandB = b;
        ctrl_destReg  = d;
        c0 = cyc + 1;
        if (expect_it) begin
            x.res = r; x.exc = e; x.dest = d; x.wb = (d != 5'd0); x.cyc = c0 + lat;
            q.push_back(x);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
        ctrl_destReg  = 5'd17;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending results", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clock);
        chk("reset_result", 64'(data_result), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_dest", 64'(data_destReg), 64'd0);
        ctrl_reset = 1'b0;
        @(negedge clock);

        // 7 * -6 = -42, with busy window checks
        start_op(0, 32'd7, 32'hFFFF_FFFA, 5'd5, 1, 32'hFFFF_FFD6, 1'b0, 33, c0);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_cyc(c0 + 31);
        chk("busy_last_iter", 64'(busy), 64'd1);
        @(negedge clock);
        chk("busy_finalize", 64'(busy), 64'd0);
        chk("rdy_not_early", 64'(data_resultRDY), 64'd0);
        drain();

        // 2^16 * 2^16 overflows
        start_op(0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1, 32'h0, 1'b1, 33, c0);
        drain();

        // largest positive times 1, then a DIV accepted while in DONE
        start_op(0, 32'h7FFF_FFFF, 32'd1, 5'd31, 1, 32'h7FFF_FFFF, 1'b0, 33, c0);
        wait_cyc(c0 + 33);
        start_op(1, 32'hFFFF_FFF9, 32'd2, 5'd0, 1, 32'hFFFF_FFFD, 1'b0, 33, c0);
        drain();

        // most negative / -1 overflows
        start_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1, 32'h8000_0000, 1'b1, 33, c0);
        drain();

        // -100 / -7 = 14
        start_op(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd9, 1, 32'd14, 1'b0, 33, c0);
        drain();

        // most negative * -1 overflows
        start_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 32'h8000_0000, 1'b1, 33, c0);
        drain();

        // divide by zero
        start_op(1, 32'd5, 32'd0, 5'd2, 1, 32'd0, 1'b1, DIV0_LAT, c0);
        chk("div0_busy", 64'(busy), (DIV0_LAT == 1) ? 64'd0 : 64'd1);
        drain();

        // start while iterating is ignored
        start_op(0, 32'd3, 32'd4, 5'd6, 1, 32'd12, 1'b0, 33, c0);
        repeat (3) @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3; ctrl_destReg = 5'd7;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();

        // reset mid-operation aborts with no result strobe
        start_op(0, 32'd5, 32'd5, 5'd8, 0, 32'd0, 1'b0, 33, c0);
        wait_cyc(c0 + 9);
        ctrl_reset = 1'b1;
        @(negedge clock);
        ctrl_reset = 1'b0;
        chk("abort_result", 64'(data_result), 64'd0);
        chk("abort_exc", 64'(data_exception), 64'd0);
        chk("abort_dest", 64'(data_destReg), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rdy", 64'(data_resultRDY), 64'd0);
        repeat (40) @(negedge clock);
        start_op(0, 32'd2, 32'd3, 5'd10, 1, 32'd6, 1'b0, 33, c0);
        drain();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
